// File: rtl/tech_cg_ctrl.sv
// Multi-channel clock-gate controller: per-channel ON/DRAIN/OFF/WAKE FSM with
// software gating, idle-timeout auto-gating, drain and wake delays, one tech_cg per channel.

module tech_cg (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    // Enable is captured while clk is low so a change can never clip a high phase.
    logic en_q;

    always_ff @(negedge clk) begin
        en_q <= en;
    end

    assign gclk = clk & en_q;

endmodule

module tech_cg_ctrl #(
    parameter int N_CH         = 4,
    parameter int IDLE_CYCLES  = 16,
    parameter int DRAIN_CYCLES = 2,
    parameter int WAKE_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            test_en,
    input  logic [N_CH-1:0] sw_en,
    input  logic [N_CH-1:0] auto_en,
    input  logic [N_CH-1:0] busy,
    input  logic [N_CH-1:0] wake_req,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] clk_on,
    output logic [N_CH-1:0] clk_off
);

    localparam int MAX_ID  = (IDLE_CYCLES > DRAIN_CYCLES) ? IDLE_CYCLES : DRAIN_CYCLES;
    localparam int MAX_CNT = (MAX_ID > WAKE_CYCLES) ? MAX_ID : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LD   = CNT_W'(WAKE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } cg_state_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        cg_state_e        state_q, state_d;
        logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
        logic [CNT_W-1:0] dly_cnt_q, dly_cnt_d;
        logic             clk_on_q, clk_on_d;
        logic             clk_off_q, clk_off_d;
        logic             idle_exp;
        logic             gate_en;

        assign idle_exp = auto_en[i] & ~busy[i] & (idle_cnt_q == IDLE_LAST);

        always_comb begin
            state_d    = state_q;
            dly_cnt_d  = dly_cnt_q;
            idle_cnt_d = '0;

            case (state_q)
                ST_ON: begin
                    if (busy[i]) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q != IDLE_MAX) begin
                        idle_cnt_d = idle_cnt_q + CNT_ONE;
                    end else begin
                        idle_cnt_d = idle_cnt_q;
                    end
                    if (~sw_en[i] | idle_exp) begin
                        state_d   = ST_DRAIN;
                        dly_cnt_d = DRAIN_LD;
                    end
                end
                ST_DRAIN: begin
                    // Renewed activity beats an expiring drain in the same cycle.
                    if (sw_en[i] & (busy[i] | wake_req[i])) begin
                        state_d = ST_ON;
                    end else if (dly_cnt_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        dly_cnt_d = dly_cnt_q - CNT_ONE;
                    end
                end
                ST_OFF: begin
                    // busy comes from the stopped domain, so it cannot wake us.
                    if (sw_en[i] & (wake_req[i] | ~auto_en[i])) begin
                        state_d   = ST_WAKE;
                        dly_cnt_d = WAKE_LD;
                    end
                end
                ST_WAKE: begin
                    if (dly_cnt_q == '0) begin
                        state_d = ST_ON;
                    end else begin
                        dly_cnt_d = dly_cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_ON;
                end
            endcase

            clk_on_d  = (state_d == ST_ON);
            clk_off_d = (state_d == ST_OFF);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_ON;
                idle_cnt_q <= '0;
                dly_cnt_q  <= '0;
                clk_on_q   <= 1'b1;
                clk_off_q  <= 1'b0;
            end else begin
                state_q    <= state_d;
                idle_cnt_q <= idle_cnt_d;
                dly_cnt_q  <= dly_cnt_d;
                clk_on_q   <= clk_on_d;
                clk_off_q  <= clk_off_d;
            end
        end

        // Derived from registered state only, so the gate enable never glitches.
        assign gate_en = (state_q != ST_OFF) | test_en;

        tech_cg u_cg (
            .clk  (clk),
            .en   (gate_en),
            .gclk (clk_out[i])
        );

        assign clk_on[i]  = clk_on_q;
        assign clk_off[i] = clk_off_q;
    end

endmodule

// File: tb/tb_tech_cg_ctrl.sv
// Randomized bench for tech_cg_ctrl against a cycle-level behavioural model of
// the per-channel gating rules (phase + cycles-spent bookkeeping).

module tb_tech_cg_ctrl;

    localparam int N    = 4;
    localparam int IDLE = 16;
    localparam int DR   = 2;
    localparam int WK   = 2;

    localparam int M_ON    = 0;
    localparam int M_DRAIN = 1;
    localparam int M_OFF   = 2;
    localparam int M_WAKE  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         test_en;
    logic [N-1:0] sw_en, auto_en, busy, wake_req;
    logic [N-1:0] clk_out, clk_on, clk_off;

    always #5 clk = ~clk;

    tech_cg_ctrl #(
        .N_CH         (N),
        .IDLE_CYCLES  (IDLE),
        .DRAIN_CYCLES (DR),
        .WAKE_CYCLES  (WK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .test_en  (test_en),
        .sw_en    (sw_en),
        .auto_en  (auto_en),
        .busy     (busy),
        .wake_req (wake_req),
        .clk_out  (clk_out),
        .clk_on   (clk_on),
        .clk_off  (clk_off)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase per channel, consecutive idle cycles seen in ON, cycles spent in a delay phase.
    int m_mode [N];
    int m_idle [N];
    int m_spent[N];
    bit m_valid = 1'b0;

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_mode[c]  = M_ON;
                m_idle[c]  = 0;
                m_spent[c] = 0;
            end else begin
                case (m_mode[c])
                    M_ON: begin
                        bit expire;
                        expire = auto_en[c] && !busy[c] && (m_idle[c] == IDLE - 1);
                        m_idle[c] = busy[c] ? 0 : ((m_idle[c] > IDLE) ? m_idle[c] : m_idle[c] + 1);
                        if (!sw_en[c] || expire) begin
                            m_mode[c]  = M_DRAIN;
                            m_spent[c] = 0;
                        end
                    end
                    M_DRAIN: begin
                        m_idle[c] = 0;
                        if (sw_en[c] && (busy[c] || wake_req[c])) begin
                            m_mode[c] = M_ON;
                        end else begin
                            m_spent[c]++;
                            if (m_spent[c] == DR + 1) m_mode[c] = M_OFF;
                        end
                    end
                    M_OFF: begin
                        m_idle[c] = 0;
                        if (sw_en[c] && (wake_req[c] || !auto_en[c])) begin
                            m_mode[c]  = M_WAKE;
                            m_spent[c] = 0;
                        end
                    end
                    default: begin
                        m_idle[c] = 0;
                        m_spent[c]++;
                        if (m_spent[c] == WK + 1) m_mode[c] = M_ON;
                    end
                endcase
            end
        end
        if (rst) m_valid = 1'b1;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later while clk is high.
    task automatic cycle();
        int           pre_mode[N];
        bit           pre_valid;
        logic         te;
        logic [N-1:0] exp_on, exp_off, exp_out;
        @(posedge clk);
        pre_mode  = m_mode;
        pre_valid = m_valid;
        te        = test_en;
        model_step();
        #1;
        for (int c = 0; c < N; c++) begin
            exp_on[c]  = (m_mode[c] == M_ON);
            exp_off[c] = (m_mode[c] == M_OFF);
            exp_out[c] = (pre_mode[c] != M_OFF) || te;
        end
        check("clk_on", 32'(clk_on), 32'(exp_on));
        check("clk_off", 32'(clk_off), 32'(exp_off));
        if (pre_valid) check("clk_out", 32'(clk_out), 32'(exp_out));
    endtask

    initial begin
        int busy_pct, sw_off_pct, wake_pct, auto_pct, te_pct;
        rst      = 1'b1;
        test_en  = 1'b0;
        sw_en    = '1;
        auto_en  = '1;
        busy     = '0;
        wake_req = '0;

        cycle();
        cycle();
        check("reset_on", 32'(clk_on), 32'hF);
        check("reset_off", 32'(clk_off), 32'h0);
        rst = 1'b0;

        // Idle from reset: all channels drain and gate together.
        for (int k = 0; k < 25; k++) cycle();
        check("idle_all_off", 32'(clk_off), 32'hF);
        check("idle_clk_stopped", 32'(clk_out), 32'h0);

        // DFT override on fully gated channels.
        test_en = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("te_clk_running", 32'(clk_out), 32'hF);
        check("te_off_kept", 32'(clk_off), 32'hF);
        test_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();

        for (int p = 0; p < 48; p++) begin
            busy_pct   = (p % 4 == 0) ? 0 : ((p % 4 == 1) ? 5 : ((p % 4 == 2) ? 30 : 70));
            sw_off_pct = (p % 3 == 0) ? 0 : ((p % 3 == 1) ? 3 : 25);
            wake_pct   = (p % 5 == 0) ? 15 : 2;
            auto_pct   = (p % 6 == 5) ? 40 : 95;
            te_pct     = (p % 7 == 3) ? 30 : 0;
            for (int k = 0; k < 50; k++) begin
                for (int c = 0; c < N; c++) begin
                    busy[c]     = ($urandom_range(99) < busy_pct);
                    sw_en[c]    = ($urandom_range(99) >= sw_off_pct);
                    wake_req[c] = ($urandom_range(99) < wake_pct);
                    auto_en[c]  = ($urandom_range(99) < auto_pct);
                end
                test_en = ($urandom_range(99) < te_pct);
                rst     = ($urandom_range(299) == 0);
                cycle();
            end
        end

        rst = 1'b0;
        test_en = 1'b0;
        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tech_cg_ctrl.md
Name: tech_cg_ctrl

Overview:
Multi-channel clock-gate controller. Wraps one tech_cg cell per channel and adds software gating, idle-timeout auto-gating, a drain delay before gating and a wake delay before the clock is reported usable. Sits in the SoC clock/reset subsystem. It is fed by the free-running system clock and drives gated clocks to the student/peripheral subsystems. Status goes back to the control registers.

Parameters:
N_CH, 4, number of gated clock channels (>=1)
IDLE_CYCLES, 16, consecutive idle (busy=0) cycles before auto-gating (>=1)
DRAIN_CYCLES, 2, extra cycles the clock keeps running after the gate decision (>=0)
WAKE_CYCLES, 2, cycles the clock runs after ungating before clk_on asserts (>=0)
CNT_W, derived, $clog2(max(IDLE_CYCLES,DRAIN_CYCLES,WAKE_CYCLES)+1)

Ports:
clk  in  1  free-running clock; the FSMs run on it and it is never gated
rst  in  1  synchronous reset, active-high
test_en  in  1  DFT override; forces all gate enables to 1 without affecting FSM state
sw_en  in  N_CH  software clock enable per channel
auto_en  in  N_CH  per-channel enable for idle auto-gating
busy  in  N_CH  channel activity indication, from the gated domain
wake_req  in  N_CH  wake request from the ungated domain (level)
clk_out  out  N_CH  gated clocks, one tech_cg instance per channel
clk_on  out  N_CH  registered, 1 iff channel state == ON
clk_off  out  N_CH  registered, 1 iff channel state == OFF

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. Reset takes every channel to ON, clears all counters, and sets clk_on=all 1, clk_off=all 0.
- Clocks run after reset so downstream blocks see their reset. The gate enable is 1 in the cycle following the reset edge.
- Channels are independent: per channel there is a 2-bit FSM {ON, DRAIN, OFF, WAKE}, an idle counter and a delay counter.
- gate_en[i] = (state != OFF) | test_en. It is derived only from registered state, so it is glitch-free. It feeds tech_cg.en.
- Gating timing: state entering OFF at rising edge k → edge k+1 suppressed on clk_out[i]. Leaving OFF at edge k → edge k+1 present.
- ON:
  - idle_cnt increments on each cycle with busy[i]=0 and saturates at IDLE_CYCLES. It clears on busy[i]=1.
  - idle_exp = auto_en[i] & ~busy[i] & (idle_cnt == IDLE_CYCLES-1). That is, IDLE_CYCLES consecutive idle cycles.
  - If ~sw_en[i] | idle_exp → DRAIN, with dly_cnt=DRAIN_CYCLES.
- DRAIN:
  - If sw_en[i] & (busy[i] | wake_req[i]) → ON (abort).
  - Else if dly_cnt == 0 → OFF.
  - Else dly_cnt--.
  - DRAIN therefore lasts DRAIN_CYCLES+1 cycles. Abort has priority over expiry in the same cycle.
- OFF: if sw_en[i] & (wake_req[i] | ~auto_en[i]) → WAKE, with dly_cnt=WAKE_CYCLES.
- WAKE:
  - Not abortable. If dly_cnt == 0 → ON, else dly_cnt--.
  - If sw_en drops during WAKE, the channel completes to ON and then drains normally.
- idle_cnt clears whenever the channel is not in ON.
- test_en=1: all clk_out[i] follow clk. FSM, clk_on and clk_off are unaffected.
- Reset mid-DRAIN, mid-OFF or mid-WAKE → ON on the next edge. The clock is ungated from the following edge onward.
- busy is ignored in OFF and WAKE, since the gated domain is stopped or stale there. Waking requires wake_req or auto_en=0.

Test Plan:
- Reset then idle, N_CH=4, IDLE=16, DRAIN=2, auto_en=F, sw_en=F, busy=0 → all channels DRAIN at cycle 16, OFF at cycle 19. clk_out edges stop from cycle 20. clk_off=F.
- Ch0 OFF, wake_req[0] pulsed for 1 cycle at edge k, WAKE=2 → WAKE at k, clk_out[0] edges resume at k+1, clk_on[0]=1 after edge k+3.
- Ch1 ON, sw_en[1] 1→0 at edge k, busy=1 throughout → OFF at k+3 despite busy. Other channels unchanged.
- Ch2 in DRAIN, sw_en=1, busy[2]=1 asserted in the 2nd DRAIN cycle → returns to ON, clk_out[2] never stops, idle_cnt restarts from 0.
- All channels OFF, test_en=1 → clk_out toggles on all channels, clk_off still F. Deassert test_en → clocks stop the next edge.
- Ch3 in WAKE, rst=1 for 1 cycle → clk_on[3]=1 and state ON after the reset edge. No clk_out edge missed after release.
